// File: rtl/hs_rx_endpoint.sv
// Four-phase handshake receiver: synchronizes a foreign breq into bclk, captures
// bdata into a single holding slot and applies backpressure by withholding back.
module hs_rx_endpoint #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             bclk,
    input  logic             brst_n,
    input  logic             breq,
    input  logic [WIDTH-1:0] bdata,
    output logic             back,
    input  logic             bload,
    output logic             bvalid,
    output logic [WIDTH-1:0] dout,
    output logic [7:0]       bcnt
);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_next;
    logic                   w_req_s;
    logic                   w_capture;
    logic                   r_bvalid;
    logic [WIDTH-1:0]       r_dout;
    logic [7:0]             r_bcnt;

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], breq};
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Capture only from IDLE, and only when the slot is empty or being drained this edge.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_s && (!r_bvalid || bload)) begin
                    w_capture = 1'b1;
                    w_next    = ACK;
                end
            end
            ACK: begin
                if (!w_req_s) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            r_bvalid <= 1'b0;
            r_dout   <= '0;
            r_bcnt   <= '0;
        end else if (w_capture) begin
            r_bvalid <= 1'b1;
            r_dout   <= bdata;
            r_bcnt   <= r_bcnt + 8'd1;
        end else if (r_bvalid && bload) begin
            r_bvalid <= 1'b0;
        end
    end

    assign back   = (r_state == ACK);
    assign bvalid = r_bvalid;
    assign dout   = r_dout;
    assign bcnt   = r_bcnt;

endmodule

// File: doc/hs_rx_endpoint.md
HS_RX_ENDPOINT -- requirements
Module: hs_rx_endpoint

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for breq; legal values 2..4.
REQ-003 bclk  input  1  sole clock of the block; all state on its rising edge.
REQ-004 brst_n  input  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
REQ-005 breq  input  1  four-phase request from the foreign sender domain; asynchronous to bclk.
REQ-006 bdata  input  WIDTH  sender data; stable by protocol from breq rise until back is seen high by the sender.
REQ-007 back  output  1  four-phase acknowledge returned to the sender; registered, glitch-free.
REQ-008 bload  input  1  local consumer accept strobe; the word is consumed on any edge where bvalid=1 and bload=1.
REQ-009 bvalid  output  1  dout holds an unconsumed word.
REQ-010 dout  output  WIDTH  captured word; registered.
REQ-011 bcnt  output  8  count of words captured since reset; wraps 255->0.

Function
REQ-012 breq passes through a SYNC_STAGES-deep flop chain clocked by bclk; only the last stage (req_s) is used by logic; breq and bdata never drive logic before this point, except bdata into the dout capture register.
REQ-013 FSM states: IDLE (back=0), ACK (back=1).
REQ-014 IDLE->ACK when req_s=1 and the holding slot is free (bvalid=0, or bvalid=1 with bload=1 on the same edge); on that edge dout<=bdata, bvalid<=1, back<=1, bcnt<=bcnt+1.
REQ-015 IDLE with req_s=1 and slot occupied (bvalid=1, bload=0): no capture, back stays 0; this is the backpressure mechanism; capture occurs on the first edge the slot frees.
REQ-016 ACK->IDLE when req_s=0; back<=0 on that edge. The FSM stays in ACK while req_s=1 and never captures in ACK.
REQ-017 bvalid clears on an edge with bvalid=1, bload=1 and no capture; capture plus consume on the same edge leaves bvalid=1 with the new word on dout.
REQ-018 bload while bvalid=0 is ignored; dout holds its last value.
REQ-019 Latency: with the slot free, bvalid and back rise on the (SYNC_STAGES+1)th bclk rising edge that samples breq=1 (edge 3 by default).
REQ-020 Latency: back falls on the (SYNC_STAGES+1)th edge that samples breq=0 after breq drops.
REQ-021 Each breq pulse yields exactly one capture; breq held high indefinitely yields one word only.
REQ-022 Throughput bound: one word per full four-phase cycle, min 2*(SYNC_STAGES+1) bclk cycles per word with the sender responding instantly.
REQ-023 bcnt increments only on capture, modulo 256, independent of WIDTH.

Reset
REQ-024 brst_n=0 asynchronously forces: synchronizer flops 0, FSM IDLE, back=0, bvalid=0, dout=0, bcnt=0.
REQ-025 Reset mid-handshake (ACK state, or word pending) discards the pending word and the in-flight request state; after release with breq still high, the block treats it as a new request and captures bdata once.
REQ-026 brst_n deassertion takes effect on the first bclk edge after release; no output changes on that release without a clock edge.

Verification
REQ-027 Reset then breq=1 with bdata=8'hA5, bload=0 -> bvalid=1, dout=8'hA5, back=1 on the 3rd edge; bcnt=1.
REQ-028 Continuing: breq=0 -> back=0 after 3 edges; bvalid stays 1, dout=8'hA5; bload=1 for one edge -> bvalid=0.
REQ-029 Word pending (dout=8'h11, bload=0), new breq=1 with bdata=8'h22 -> back stays 0 and dout=8'h11 indefinitely; bload=1 one edge -> same edge dout=8'h22, bvalid=1, back=1, bcnt+1.
REQ-030 bload held 1, sender loop of 300 words with bdata=count -> every word seen once in order, bcnt wraps to 44 (300 mod 256), no back toggle without a capture.
REQ-031 Assert brst_n=0 while in ACK with bvalid=1 -> back, bvalid, dout, bcnt all 0 immediately without a clock; release with breq=1, bdata=8'h3C -> single capture of 8'h3C, bcnt=1.
REQ-032 SYNC_STAGES=3 build, repeat REQ-027 -> rise on the 4th edge.
